irq_arbiter: RTL and testbench

// - Platform-level external interrupt controller in front of the CPU CSR unit: gathers NUM_SRC level

---
 rtl/irq_arbiter.sv | 109 ++++++++++
 tb/tb_irq_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// External interrupt arbiter: latches level interrupt lines through per-source gateways,
// masks them with an enable register and serves claim/complete cycles from ISR software.
module irq_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               cfg_wen,
    input  logic               cfg_ren,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               ex_interrupt
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] ADDR_INSVC   = 2'd3;

    // Gateway state per source: pend and insvc are mutually exclusive; both clear means IDLE.
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic               ex_interrupt_q, ex_interrupt_d;

    logic [ID_W-1:0]    best_id;
    logic [ID_W-1:0]    complete_id;
    logic               claim_hit;
    logic               complete_hit;
    logic               enable_wr;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:NUM_SRC];

    // Lowest-numbered enabled pending source wins.
    always_comb begin
        best_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_q[i] && enable_q[i]) begin
                best_id = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        complete_id  = cfg_wdata[ID_W-1:0];
        claim_hit    = cfg_ren && (cfg_addr == ADDR_CLAIM) && (best_id != '0);
        complete_hit = cfg_wen && (cfg_addr == ADDR_CLAIM);
        enable_wr    = cfg_wen && (cfg_addr == ADDR_ENABLE);
    end

    // Claim and complete both look at pre-edge state, so a complete of the ID being claimed
    // this cycle finds it not yet in service and is dropped.
    always_comb begin
        pend_d  = pend_q;
        insvc_d = insvc_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim_hit && (best_id == ID_W'(i + 1))) begin
                pend_d[i]  = 1'b0;
                insvc_d[i] = 1'b1;
            end
            if (complete_hit && insvc_q[i] && (complete_id == ID_W'(i + 1))) begin
                insvc_d[i] = 1'b0;
            end
            if (!pend_q[i] && !insvc_q[i] && src_irq[i]) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        enable_d = enable_q;
        if (enable_wr) begin
            enable_d = cfg_wdata[NUM_SRC-1:0];
        end
        ex_interrupt_d = |(pend_q & enable_q);
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata[NUM_SRC-1:0] = enable_q;
            ADDR_PENDING: cfg_rdata[NUM_SRC-1:0] = pend_q;
            ADDR_CLAIM:   cfg_rdata[ID_W-1:0]    = best_id;
            ADDR_INSVC:   cfg_rdata[NUM_SRC-1:0] = insvc_q;
            default:      cfg_rdata              = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q       <= '0;
            pend_q         <= '0;
            insvc_q        <= '0;
            ex_interrupt_q <= 1'b0;
        end else begin
            enable_q       <= enable_d;
            pend_q         <= pend_d;
            insvc_q        <= insvc_d;
            ex_interrupt_q <= ex_interrupt_d;
        end
    end

    assign ex_interrupt = ex_interrupt_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized and directed bench for irq_arbiter; a per-source gateway model predicts reads
// and ex_interrupt, expectations flow through queues to an independent monitor.
module tb_irq_arbiter;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 5;

    localparam int ST_IDLE  = 0;
    localparam int ST_PEND  = 1;
    localparam int ST_INSVC = 2;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] src_irq;
    logic               cfg_wen;
    logic               cfg_ren;
    logic [1:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               ex_interrupt;

    irq_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_irq      (src_irq),
        .cfg_wen      (cfg_wen),
        .cfg_ren      (cfg_ren),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .ex_interrupt (ex_interrupt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    int          m_state [NUM_SRC];
    bit          m_en    [NUM_SRC];
    bit          m_ex;
    bit          m_valid;

    // scoreboard
    logic [31:0] exp_q[$];
    logic [0:0]  ex_q[$];
    int          n_chk;
    int          n_pass;

    function automatic int model_best();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_state[i] == ST_PEND && m_en[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            case (addr)
                2'd0: v[i] = m_en[i];
                2'd1: v[i] = (m_state[i] == ST_PEND);
                2'd3: v[i] = (m_state[i] == ST_INSVC);
                default: ;
            endcase
        end
        if (addr == 2'd2) v = 32'(model_best());
        return v;
    endfunction

    task automatic model_edge();
        int pre [NUM_SRC];
        int b;
        int cid;
        bit any;
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                m_state[i] = ST_IDLE;
                m_en[i]    = 1'b0;
            end
            m_ex    = 1'b0;
            m_valid = 1'b1;
            return;
        end
        any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pre[i] = m_state[i];
            if (m_state[i] == ST_PEND && m_en[i]) any = 1'b1;
        end
        b   = model_best();
        cid = int'(cfg_wdata[ID_W-1:0]);
        if (cfg_ren && cfg_addr == 2'd2 && b != 0) m_state[b-1] = ST_INSVC;
        if (cfg_wen && cfg_addr == 2'd2 && cid >= 1 && cid <= NUM_SRC && pre[cid-1] == ST_INSVC)
            m_state[cid-1] = ST_IDLE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pre[i] == ST_IDLE && src_irq[i]) m_state[i] = ST_PEND;
        end
        if (cfg_wen && cfg_addr == 2'd0) begin
            for (int i = 0; i < NUM_SRC; i++) m_en[i] = cfg_wdata[i];
        end
        m_ex = any;
    endtask

    // driver: one clock cycle with the given inputs; peek checks rdata without cfg_ren
    task automatic step(input logic [NUM_SRC-1:0] src, input logic wen, input logic ren,
                        input logic [1:0] addr, input logic [31:0] wdata, input logic r,
                        input logic peek);
        src_irq   = src;
        cfg_wen   = wen;
        cfg_ren   = ren;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        rst       = r;
        if (m_valid) begin
            ex_q.push_back(m_ex);
            if (ren || peek) exp_q.push_back(model_read(addr));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [NUM_SRC-1:0] src);
        step(src, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [NUM_SRC-1:0] src, input logic [1:0] addr);
        step(src, 1'b0, 1'b1, addr, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [NUM_SRC-1:0] src, input logic [1:0] addr, input logic [31:0] d);
        step(src, 1'b1, 1'b0, addr, d, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [NUM_SRC-1:0] src);
        step(src, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        step(src, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic rd_all(input logic [NUM_SRC-1:0] src);
        for (int a = 0; a < 4; a++) begin
            if (a == 2) step(src, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b1);
            else rd(src, 2'(a));
        end
    endtask

    // monitor: compare whatever the driver queued for this cycle
    always @(negedge clk) begin
        logic [31:0] e;
        logic [0:0]  x;
        if (ex_q.size() > 0) begin
            x = ex_q.pop_front();
            n_chk++;
            if (ex_interrupt === x[0]) n_pass++;
            else $display("FAIL ex_interrupt at %0t: got %b exp %b", $time, ex_interrupt, x[0]);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (cfg_rdata === e) n_pass++;
            else $display("FAIL rdata addr%0d at %0t: got %h exp %h", cfg_addr, $time, cfg_rdata, e);
        end
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        m_valid = 1'b0;
        m_ex    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m_state[i] = ST_IDLE;
            m_en[i]    = 1'b0;
        end

        // reset state, then pending without enable
        do_reset(8'h00);
        rd_all(8'h00);
        idle(8'h01);
        idle(8'h01);
        rd(8'h01, 2'd1);
        idle(8'h00);

        // latency: one-cycle pulse on source 3
        do_reset(8'h00);
        wr(8'h00, 2'd0, 32'hFFFF_FFFF);
        rd(8'h00, 2'd0);
        idle(8'h04);
        idle(8'h00);
        idle(8'h00);
        rd(8'h00, 2'd2);
        rd(8'h00, 2'd1);
        rd(8'h00, 2'd3);
        idle(8'h00);

        // priority
        do_reset(8'h00);
        wr(8'hA0, 2'd0, 32'h0000_00FF);
        idle(8'h00);
        step(8'h00, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b1);
        rd(8'h00, 2'd2);
        rd(8'h00, 2'd2);
        rd(8'h00, 2'd2);
        rd(8'h00, 2'd3);

        // level re-arm and ignored completes
        do_reset(8'h00);
        wr(8'h01, 2'd0, 32'h0000_00FF);
        idle(8'h01);
        rd(8'h01, 2'd2);
        wr(8'h01, 2'd2, 32'd1);
        idle(8'h01);
        rd(8'h01, 2'd1);
        rd(8'h01, 2'd2);
        wr(8'h01, 2'd2, 32'd5);
        wr(8'h01, 2'd2, 32'd0);
        wr(8'h01, 2'd2, 32'd9);
        rd(8'h01, 2'd3);

        // simultaneous claim/complete
        do_reset(8'h00);
        wr(8'h02, 2'd0, 32'h0000_00FF);
        idle(8'h00);
        rd(8'h00, 2'd2);
        idle(8'h08);
        idle(8'h00);
        step(8'h00, 1'b1, 1'b1, 2'd2, 32'd2, 1'b0, 1'b0);
        rd(8'h00, 2'd3);
        rd(8'h00, 2'd1);
        // completing the ID being claimed in the same cycle is dropped
        idle(8'h01);
        idle(8'h00);
        step(8'h00, 1'b1, 1'b1, 2'd2, 32'd1, 1'b0, 1'b0);
        rd(8'h00, 2'd3);

        // disable masks but keeps pending
        wr(8'h00, 2'd0, 32'h0000_0000);
        idle(8'h00);
        rd(8'h00, 2'd1);

        // mid-operation reset
        wr(8'hFF, 2'd0, 32'hFFFF_FFFF);
        idle(8'hFF);
        rd(8'hFF, 2'd2);
        rd(8'hFF, 2'd2);
        step(8'hFF, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        rd_all(8'hFF);
        idle(8'hFF);
        rd(8'hFF, 2'd1);

        // randomized traffic
        do_reset(8'h00);
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_SRC-1:0] s;
            logic [1:0]         a;
            logic [31:0]        d;
            int                 op;
            s  = NUM_SRC'($urandom) & NUM_SRC'($urandom);
            a  = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 99);
            d  = (a == 2'd2) ? 32'($urandom_range(0, 10)) : $urandom;
            if (op < 2)       step(s, 1'b0, 1'b0, a, d, 1'b1, 1'b0);
            else if (op < 35) step(s, 1'b0, 1'b1, a, d, 1'b0, 1'b0);
            else if (op < 65) step(s, 1'b1, 1'b0, a, d, 1'b0, 1'b1);
            else if (op < 75) step(s, 1'b1, 1'b1, a, d, 1'b0, 1'b0);
            else              step(s, 1'b0, 1'b0, a, d, 1'b0, 1'b1);
        end
        idle(8'h00);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
